// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for arbiters in front of the mem_intf register memory.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RESP
   } state_t;

   localparam int DEF_ADDR_W = 4;
   localparam int DEF_DATA_W = 32;
   localparam int MAX_REQ    = 4;

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: the requester nearest after last_grant wins,
// with the search wrapping modulo N.
module mem_rr_pick #(
   parameter int N  = 2,
   parameter int GW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] last_grant,
   output logic [GW-1:0] grant,
   output logic          any_req
);

   logic [GW-1:0] idx;

   // Candidates are visited farthest-first, so the last hit is the nearest one.
   always_comb begin
      // NOTE: every output and temporary gets a default before the loop, otherwise a path
      // that leaves one unassigned infers a latch.
      grant   = last_grant;
      any_req = 1'b0;
      idx     = '0;
      for (int i = N; i >= 1; i--) begin
         idx = GW'((int'(last_grant) + i) % N);
         if (req[idx]) begin
            grant   = idx;
            any_req = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port mem_intf between NUM_REQ requesters,
// one transaction at a time, with a watchdog that aborts unacknowledged accesses.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_vld,
   input  logic [NUM_REQ-1:0]        req_rnw,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_rdy,
   output logic [NUM_REQ-1:0]        req_err,
   output logic [DATA_W-1:0]         req_rdata,
   output logic                      mem_req_vld,
   output logic                      mem_req_rnw,
   output logic [ADDR_W-1:0]         mem_req_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic                      mem_req_rdy,
   input  logic [DATA_W-1:0]         mem_rdata,
   output logic                      busy
);

   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT);

   state_t              state_q, state_d;
   logic [GW-1:0]       last_q, last_d;
   logic                rnw_q, rnw_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  rdy_q, rdy_d;
   logic [NUM_REQ-1:0]  err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                mem_vld_q, mem_vld_d;
   logic                busy_q, busy_d;

   logic [GW-1:0]       pick_grant;
   logic                pick_any;

   mem_rr_pick #(
      .N  (NUM_REQ),
      .GW (GW)
   ) u_pick (
      .req        (req_vld),
      .last_grant (last_q),
      .grant      (pick_grant),
      .any_req    (pick_any)
   );

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      rnw_d     = rnw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      mem_vld_d = mem_vld_q;
      rdy_d     = '0;
      err_d     = '0;
      rdata_d   = '0;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               rnw_d     = req_rnw[pick_grant];
               addr_d    = req_addr[pick_grant*ADDR_W +: ADDR_W];
               wdata_d   = req_wdata[pick_grant*DATA_W +: DATA_W];
               last_d    = pick_grant;
               cnt_d     = '0;
               mem_vld_d = 1'b1;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d = cnt_q + 1'b1;
            if (mem_req_rdy) begin
               rdata_d       = mem_rdata;
               rdy_d[last_q] = 1'b1;
               mem_vld_d     = 1'b0;
               state_d       = RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               // Watchdog abort: answer the requester with zero data and the error flag.
               rdy_d[last_q] = 1'b1;
               err_d[last_q] = 1'b1;
               mem_vld_d     = 1'b0;
               state_d       = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples
      // the pre-edge values regardless of statement order.
      if (!rst) begin
         state_q   <= IDLE;
         last_q    <= GW'(NUM_REQ - 1);
         rnw_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         rdy_q     <= '0;
         err_q     <= '0;
         rdata_q   <= '0;
         mem_vld_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         rnw_q     <= rnw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         rdy_q     <= rdy_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         mem_vld_q <= mem_vld_d;
         busy_q    <= busy_d;
      end
   end

   assign mem_req_vld  = mem_vld_q;
   assign mem_req_rnw  = rnw_q;
   assign mem_req_addr = addr_q;
   assign mem_wdata    = wdata_q;
   assign req_rdy      = rdy_q;
   assign req_err      = err_q;
   assign req_rdata    = rdata_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model checked every cycle,
// a behavioural mem_intf stub, and directed scenarios with literal expectations.
module tb_mem_arbiter;

   localparam int NUM_REQ = 2;
   localparam int ADDR_W  = 4;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_vld;
   logic [NUM_REQ-1:0]        req_rnw;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_rdy;
   logic [NUM_REQ-1:0]        req_err;
   logic [DATA_W-1:0]         req_rdata;
   logic                      mem_req_vld;
   logic                      mem_req_rnw;
   logic [ADDR_W-1:0]         mem_req_addr;
   logic [DATA_W-1:0]         mem_wdata;
   logic                      mem_req_rdy;
   logic [DATA_W-1:0]         mem_rdata;
   logic                      busy;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   int stub_delay = 1;
   bit stub_off   = 1'b0;
   bit spurious   = 1'b0;
   logic [DATA_W-1:0] stub_mem [16];

   always #5 clk = ~clk;

   mem_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_vld      (req_vld),
      .req_rnw      (req_rnw),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_rdy      (req_rdy),
      .req_err      (req_err),
      .req_rdata    (req_rdata),
      .mem_req_vld  (mem_req_vld),
      .mem_req_rnw  (mem_req_rnw),
      .mem_req_addr (mem_req_addr),
      .mem_wdata    (mem_wdata),
      .mem_req_rdy  (mem_req_rdy),
      .mem_rdata    (mem_rdata),
      .busy         (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int rr_winner(input logic [NUM_REQ-1:0] vld, input int last);
      for (int s = 1; s <= NUM_REQ; s++)
         if (vld[(last + s) % NUM_REQ]) return (last + s) % NUM_REQ;
      return -1;
   endfunction

   function automatic logic [NUM_REQ-1:0] onehot(input int i);
      return NUM_REQ'(1) << i;
   endfunction

   // Transaction model: one access at a time, granted from idle, finished by the
   // memory answer or after TIMEOUT cycles in flight, then one response cycle.
   bit                m_iss = 1'b0, m_resp = 1'b0, m_err = 1'b0;
   int                m_owner = 0, m_last = NUM_REQ - 1, m_age = 0, m_win;
   logic              m_rnw = 1'b0;
   logic [ADDR_W-1:0] m_addr = '0;
   logic [DATA_W-1:0] m_wdata = '0, m_rdata = '0;

   always_comb m_win = rr_winner(req_vld, m_last);

   always @(posedge clk) begin
      if (!rst) begin
         m_iss  <= 1'b0;
         m_resp <= 1'b0;
         m_err  <= 1'b0;
         m_last <= NUM_REQ - 1;
      end else if (m_resp) begin
         m_resp <= 1'b0;
      end else if (m_iss) begin
         if (mem_req_rdy) begin
            m_iss   <= 1'b0;
            m_resp  <= 1'b1;
            m_err   <= 1'b0;
            m_rdata <= mem_rdata;
         end else if (m_age + 1 == TIMEOUT) begin
            m_iss   <= 1'b0;
            m_resp  <= 1'b1;
            m_err   <= 1'b1;
            m_rdata <= '0;
         end else begin
            m_age <= m_age + 1;
         end
      end else if (m_win >= 0) begin
         m_iss   <= 1'b1;
         m_age   <= 0;
         m_owner <= m_win;
         m_last  <= m_win;
         m_rnw   <= req_rnw[m_win];
         m_addr  <= req_addr[m_win*ADDR_W +: ADDR_W];
         m_wdata <= req_wdata[m_win*DATA_W +: DATA_W];
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("mem_req_vld", 64'(mem_req_vld), 64'(m_iss));
         check("busy", 64'(busy), 64'(m_iss | m_resp));
         check("req_rdy", 64'(req_rdy), 64'(m_resp ? onehot(m_owner) : '0));
         check("req_err", 64'(req_err), 64'((m_resp && m_err) ? onehot(m_owner) : '0));
         if (m_iss) begin
            check("mem_req_rnw", 64'(mem_req_rnw), 64'(m_rnw));
            check("mem_req_addr", 64'(mem_req_addr), 64'(m_addr));
            check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
         end
         if (m_resp) check("req_rdata", 64'(req_rdata), 64'(m_rdata));
      end
   end

   // mem_intf stub: answers stub_delay cycles after it first sees a command.
   initial begin : stub
      int wait_cnt;
      wait_cnt    = 0;
      mem_req_rdy = 1'b0;
      mem_rdata   = '0;
      for (int i = 0; i < 16; i++) stub_mem[i] = '0;
      forever begin
         @(negedge clk);
         mem_req_rdy = spurious;
         if (mem_req_vld && !stub_off) begin
            if (wait_cnt == stub_delay) begin
               mem_req_rdy = 1'b1;
               if (mem_req_rnw) begin
                  mem_rdata = stub_mem[mem_req_addr];
               end else begin
                  stub_mem[mem_req_addr] = mem_wdata;
                  mem_rdata = 32'h5A5A_0000 | 32'(mem_req_addr);
               end
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   task automatic set_cmd(input int i, input logic rnw, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
      req_rnw[i]                   = rnw;
      req_addr[i*ADDR_W +: ADDR_W] = a;
      req_wdata[i*DATA_W +: DATA_W] = d;
   endtask

   // Returns the first non-zero req_rdy and the negedge count at which it appeared.
   task automatic wait_rdy(output logic [NUM_REQ-1:0] seen, output int cyc);
      seen = '0;
      cyc  = 0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (req_rdy != '0) begin
            seen = req_rdy;
            cyc  = k;
            break;
         end
      end
   endtask

   initial begin
      logic [NUM_REQ-1:0] seen;
      int                 cyc;
      int                 win;

      rst       = 1'b0;
      req_vld   = '0;
      req_rnw   = '0;
      req_addr  = '0;
      req_wdata = '0;

      // Reset held with both requesters asking.
      set_cmd(0, 1'b0, 4'h1, 32'h1111_0000);
      set_cmd(1, 1'b0, 4'h2, 32'h2222_0000);
      req_vld = 2'b11;
      @(posedge clk);
      chk_en = 1'b1;
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         check("rst_mem_req_vld", 64'(mem_req_vld), 64'd0);
         check("rst_mem_req_rnw", 64'(mem_req_rnw), 64'd0);
         check("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
         check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
         check("rst_req_rdy", 64'(req_rdy), 64'd0);
         check("rst_req_err", 64'(req_err), 64'd0);
         check("rst_req_rdata", 64'(req_rdata), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
      end
      rst = 1'b1;
      wait_rdy(seen, cyc);
      check("first_grant_after_rst", 64'(seen), 64'b01);
      req_vld[0] = 1'b0;
      wait_rdy(seen, cyc);
      check("second_grant_after_rst", 64'(seen), 64'b10);
      req_vld[1] = 1'b0;

      // Requester 1 writes 0xABCD to address 5, then reads it back with the fastest memory.
      @(negedge clk);
      set_cmd(1, 1'b0, 4'h5, 32'h0000_ABCD);
      req_vld[1] = 1'b1;
      @(negedge clk);
      check("wr_mem_req_vld", 64'(mem_req_vld), 64'd1);
      check("wr_mem_req_rnw", 64'(mem_req_rnw), 64'd0);
      check("wr_mem_req_addr", 64'(mem_req_addr), 64'h5);
      check("wr_mem_wdata", 64'(mem_wdata), 64'h0000_ABCD);
      wait_rdy(seen, cyc);
      check("wr_grant", 64'(seen), 64'b10);
      req_vld[1] = 1'b0;
      stub_delay = 0;
      @(negedge clk);
      set_cmd(1, 1'b1, 4'h5, 32'h0);
      req_vld[1] = 1'b1;
      wait_rdy(seen, cyc);
      check("rd_grant", 64'(seen), 64'b10);
      check("rd_min_latency", 64'(cyc), 64'd2);
      check("rd_data", 64'(req_rdata), 64'h0000_ABCD);
      req_vld[1] = 1'b0;

      // Contention: both hold writes; grants must alternate starting with requester 0.
      @(negedge clk);
      set_cmd(0, 1'b0, 4'h8, 32'hC000_0000);
      set_cmd(1, 1'b0, 4'h9, 32'hC100_0000);
      req_vld = 2'b11;
      for (int t = 0; t < 6; t++) begin
         wait_rdy(seen, cyc);
         win = (seen == 2'b01) ? 0 : (seen == 2'b10) ? 1 : -1;
         check("contention_grant", 64'(win), 64'(t % 2));
         if (win >= 0) set_cmd(win, 1'b0, 4'(8 + win), 32'hC000_0000 + 32'(t + 1));
         if (t == 5) req_vld = 2'b00;
      end

      // Timeout: memory never answers; response lands in the 17th cycle counted from E0.
      stub_off = 1'b1;
      @(negedge clk);
      set_cmd(0, 1'b1, 4'h3, 32'h0);
      req_vld[0] = 1'b1;
      wait_rdy(seen, cyc);
      check("to_rdy", 64'(seen), 64'b01);
      check("to_latency", 64'(cyc), 64'd17);
      check("to_err", 64'(req_err), 64'b01);
      check("to_rdata", 64'(req_rdata), 64'd0);
      req_vld[0] = 1'b0;
      @(negedge clk);
      check("to_vld_dropped", 64'(mem_req_vld), 64'd0);

      // Reset while requester 1 is in flight; requester 0 must win afterwards.
      @(negedge clk);
      set_cmd(1, 1'b1, 4'h5, 32'h0);
      req_vld = 2'b10;
      repeat (3) @(negedge clk);
      check("midrst_in_issue", 64'(mem_req_vld), 64'd1);
      set_cmd(0, 1'b1, 4'h5, 32'h0);
      req_vld = 2'b11;
      rst     = 1'b0;
      @(negedge clk);
      check("midrst_vld_low", 64'(mem_req_vld), 64'd0);
      check("midrst_no_rdy", 64'(req_rdy), 64'd0);
      check("midrst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      check("midrst_no_rdy2", 64'(req_rdy), 64'd0);
      rst        = 1'b1;
      stub_off   = 1'b0;
      stub_delay = 1;
      wait_rdy(seen, cyc);
      check("midrst_prio", 64'(seen), 64'b01);
      check("midrst_rdata", 64'(req_rdata), 64'h0000_ABCD);
      req_vld[0] = 1'b0;
      wait_rdy(seen, cyc);
      check("midrst_second", 64'(seen), 64'b10);
      req_vld[1] = 1'b0;

      // Late request: requester 1 raises req_vld during requester 0's response cycle.
      @(negedge clk);
      set_cmd(0, 1'b0, 4'h6, 32'h6666_0000);
      req_vld = 2'b01;
      wait_rdy(seen, cyc);
      check("late_first", 64'(seen), 64'b01);
      req_vld[0] = 1'b0;
      set_cmd(1, 1'b1, 4'h6, 32'h0);
      req_vld[1] = 1'b1;
      cyc = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mem_req_vld) begin
            cyc = k;
            break;
         end
      end
      check("late_grant_delay", 64'(cyc), 64'd2);
      check("late_addr", 64'(mem_req_addr), 64'h6);
      wait_rdy(seen, cyc);
      check("late_second", 64'(seen), 64'b10);
      check("late_rdata", 64'(req_rdata), 64'h6666_0000);
      req_vld[1] = 1'b0;

      // Spurious memory completion while idle is ignored.
      @(negedge clk);
      spurious = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("spur_no_rdy", 64'(req_rdy), 64'd0);
         check("spur_idle", 64'(busy), 64'd0);
      end
      spurious = 1'b0;
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single-port `mem_intf` register memory between `NUM_REQ` requesters. Each requester uses the same valid/ready request protocol that `mem_intf` exposes. The arbiter latches one command, drives it to `mem_intf`, waits for `req_rdy`, and returns a one-cycle ready pulse with read data to the winner. A watchdog aborts any access that `mem_intf` never acknowledges.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, legal range 2..4.
- `ADDR_W`, 4: address width, matches `mem_intf`.
- `DATA_W`, 32: data width, matches `mem_intf`.
- `TIMEOUT`, 16: maximum cycles spent in ISSUE before abort; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `req_vld`  in  NUM_REQ  per-requester request valid.
- `req_rnw`  in  NUM_REQ  per-requester access type: 1 = read, 0 = write.
- `req_addr`  in  NUM_REQ×ADDR_W  per-requester address, packed.
- `req_wdata`  in  NUM_REQ×DATA_W  per-requester write data, packed.
- `req_rdy`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `req_err`  out  NUM_REQ  one-cycle timeout flag, coincident with `req_rdy`.
- `req_rdata`  out  DATA_W  shared read-data return; meaningful only while a `req_rdy` bit is high.
- `mem_req_vld`, `mem_req_rnw`  out  1  command to `mem_intf`.
- `mem_req_addr`  out  ADDR_W  command address to `mem_intf`.
- `mem_wdata`  out  DATA_W  write data to `mem_intf`.
- `mem_req_rdy`  in  1  completion from `mem_intf`.
- `mem_rdata`  in  DATA_W  read data from `mem_intf`, valid while `mem_req_rdy`=1.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states are IDLE, ISSUE and RESP.
- **IDLE**
  - If any `req_vld` bit is set, pick the winner `g` by round-robin.
  - Search starts at `last_grant+1` and wraps modulo NUM_REQ.
  - Latch `req_rnw[g]`, `req_addr[g]` and `req_wdata[g]` into command registers; set `last_grant=g`; go to ISSUE.
  - No request present: stay in IDLE.
- **ISSUE**
  - `mem_req_vld=1`; command outputs come from the registers and are stable for the whole state.
  - Watchdog counter increments every cycle.
  - `mem_req_rdy`=1 sampled: capture `mem_rdata` (captured for writes too), drop `mem_req_vld` at the same edge, go to RESP.
  - Counter reaches TIMEOUT−1 with no `mem_req_rdy`: drop `mem_req_vld`, load captured data with 0, set error flag, go to RESP.
- **RESP** (exactly one cycle)
  - Drive `req_rdy[g]=1`, `req_rdata`=captured data, and `req_err[g]`=error flag.
  - Then go to IDLE.
  - All other `req_rdy`/`req_err` bits stay 0.
- **Requester obligations**
  - Hold `req_vld` and the command stable until `req_rdy` is seen.
  - Deassert `req_vld` no later than the edge that ends RESP.
  - A request withdrawn before grant is simply not served.
- Only one transaction is ever outstanding; there is no pipelining.
- Commands arriving while `busy`=1 wait; they are arbitrated in the next IDLE cycle.
- Simultaneous requests: the winner is the requester nearest after `last_grant`. Example: with `last_grant`=0 and requests {0,1}, requester 1 wins.

## Timing
- **Reset** (`rst`=0 at an edge), applied from any state:
  - state=IDLE, `last_grant`=NUM_REQ−1 so requester 0 has first priority, counter=0.
  - All outputs 0: `mem_req_vld`, `mem_req_rnw`, `mem_req_addr`, `mem_wdata`, `req_rdy`, `req_err`, `req_rdata`, `busy`.
  - Reset mid-ISSUE drops `mem_req_vld` on that edge. No `req_rdy` is issued for the aborted transaction.
- **Latency**, request sampled at edge E0:
  - `mem_req_vld` high from E0 onward.
  - `mem_req_rdy` first sampled at edge En makes `req_rdy` high for the cycle after En.
  - Minimum request-to-`req_rdy` latency is 2 cycles, with `mem_intf` answering at E1.
- **Throughput:** minimum 3 cycles per transaction (IDLE, ISSUE, RESP).
- **Timeout:** `req_rdy`+`req_err` are asserted exactly TIMEOUT+1 cycles after E0.
- **Spurious `mem_req_rdy`** seen outside ISSUE is ignored.

## Structure
- Package `mem_arb_pkg` holds:
  - `state_t` enum (IDLE, ISSUE, RESP);
  - default `ADDR_W`/`DATA_W` constants;
  - `MAX_REQ`=4.
- Sub-module `mem_rr_pick`: combinational round-robin picker.
  - Inputs: request vector and `last_grant`.
  - Outputs: grant index and `any_req`.
  - Reusable by future arbiters.
- Top level contains the FSM, command/data registers and watchdog counter.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with `req_vld`=2'b11. Required: all outputs 0 and `busy`=0; after release, requester 0 is granted first.
- **Single write then read**, requester 1:
  - Write addr 4'h5, data 32'h0000_ABCD. Required: `mem_req_*` carry exactly those values, then one `req_rdy[1]` pulse.
  - Read addr 4'h5. Required: `req_rdata`=32'h0000_ABCD during the `req_rdy[1]` pulse.
- **Contention:** both requesters hold writes continuously for 6 transactions. Required: grants alternate 0,1,0,1,0,1 and the command never changes while `mem_req_vld`=1.
- **Timeout:** stub `mem_req_rdy`=0 with TIMEOUT=16. Required: `req_rdy[0]`=`req_err[0]`=1 and `req_rdata`=0 exactly 17 cycles after the request edge; `mem_req_vld` low afterwards.
- **Mid-operation reset:** assert `rst`=0 while in ISSUE. Required: `mem_req_vld` low at the next edge, no `req_rdy` pulse, and requester 0 has priority again.
- **Late request:** requester 1 raises `req_vld` during requester 0's RESP cycle. Required: requester 1 is granted in the following IDLE cycle with no lost request.
